// File: rtl/surf_stream_pkg.sv
// Shared definitions for the SURF result streamer.
// Contents: width constants, FSM state and gearbox phase enums, tkeep constants.
package surf_stream_pkg;

   localparam int ADDR_W = 17;
   localparam int MEM_W  = 48;
   localparam int AXIS_W = 32;

   localparam logic [3:0] KEEP_FULL = 4'hF;
   localparam logic [3:0] KEEP_HALF = 4'h3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      PH_0 = 2'd0,
      PH_1 = 2'd1,
      PH_2 = 2'd2
   } phase_e;

endpackage

// File: rtl/surf_word_fifo.sv
// Two-entry word FIFO between the memory read port and the gearbox.
// Ports:
//   clk, rst (async, active-low)
//   push/din  : write a word
//   pop/dout  : read the head word (dout is the head, valid while occ != 0)
//   occ       : current occupancy (0..2)
// The fetch side never issues more reads than there is room for, so no
// full/empty protection is needed here.
module surf_word_fifo
   import surf_stream_pkg::*;
#(
   parameter int WIDTH = MEM_W
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [1:0]       occ
);

   logic [WIDTH-1:0] slot [2];
   logic             wr_ptr;
   logic             rd_ptr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot[0] <= '0;
         slot[1] <= '0;
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         occ     <= 2'd0;
      end else begin
         if (push) begin
            slot[wr_ptr] <= din;
            wr_ptr       <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         occ <= occ + 2'(push) - 2'(pop);
      end
   end

   assign dout = slot[rd_ptr];

endmodule

// File: rtl/surf_result_streamer.sv
// SURF result streamer: reads num_words 48-bit words from the output memory
// starting at base_addr and emits them as 32-bit AXI-Stream beats (two words
// per three beats, little-endian), tagging the final beat with tlast/tkeep.
// Ports:
//   clk, rst (async, active-low)
//   start, base_addr, num_words : command (start ignored while busy)
//   busy, done                  : status (done is a one-cycle pulse)
//   mem_addr, mem_en, mem_din   : memory read port, 1-cycle read latency
//   m_axis_*                    : AXI-Stream master (registered outputs)
//   stall_cnt                   : only with SURF_STREAMER_STALL_CNT_EN defined;
//                                 cycles with busy && tvalid && !tready
//
// state | meaning
// IDLE  | waiting for start
// RUN   | fetch and stream in progress
// FIN   | one-cycle done pulse, then back to IDLE
module surf_result_streamer
   import surf_stream_pkg::*;
#(
   parameter int ADDR_WIDTH      = ADDR_W,
   parameter int MEM_DATA_WIDTH  = MEM_W,
   parameter int AXIS_DATA_WIDTH = AXIS_W
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [ADDR_WIDTH-1:0]        base_addr,
   input  logic [ADDR_WIDTH-1:0]        num_words,
   output logic                         busy,
   output logic                         done,
   output logic [ADDR_WIDTH-1:0]        mem_addr,
   output logic                         mem_en,
   input  logic [MEM_DATA_WIDTH-1:0]    mem_din,
   output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
   output logic                         m_axis_tvalid,
   input  logic                         m_axis_tready,
   output logic                         m_axis_tlast,
   output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep
`ifdef SURF_STREAMER_STALL_CNT_EN
   ,
   output logic [31:0]                  stall_cnt
`endif
);

   state_e                      state, state_nx;
   phase_e                      phase, phase_nx;
   logic [31:0]                 residue, residue_nx;
   logic [ADDR_WIDTH-1:0]       issue_left;
   logic [ADDR_WIDTH-1:0]       pop_left;
   logic                        rd_vld;

   logic                        accept;
   logic                        hs;
   logic                        issue;
   logic                        load;
   logic                        take;
   logic                        consume;
   logic                        beat_ok;
   logic [31:0]                 beat_data;
   logic [3:0]                  beat_keep;
   logic                        beat_last;

   logic [MEM_DATA_WIDTH-1:0]   fifo_dout;
   logic [1:0]                  fifo_occ;
   logic [1:0]                  occ_nx;
   logic                        fifo_push;
   logic                        fifo_pop;
   logic                        word_avail;
   logic [MEM_DATA_WIDTH-1:0]   word;

   assign accept = (state == ST_IDLE) && start;
   assign hs     = m_axis_tvalid && m_axis_tready;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (start) state_nx = (num_words == '0) ? ST_FIN : ST_RUN;
         ST_RUN:  if (hs && m_axis_tlast) state_nx = ST_FIN;
         ST_FIN:  state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (state == ST_RUN);
      done = (state == ST_FIN);
   end

   // ---------------- word FIFO with fall-through ----------------
   // When the FIFO is empty the gearbox takes the returning read data
   // directly, which saves a cycle of first-beat latency.
   assign word_avail = (fifo_occ != 2'd0) || rd_vld;
   assign word       = (fifo_occ != 2'd0) ? fifo_dout : mem_din;
   assign consume    = load && take;
   assign fifo_pop   = consume && (fifo_occ != 2'd0);
   assign fifo_push  = rd_vld && !(consume && (fifo_occ == 2'd0));
   assign occ_nx     = fifo_occ + 2'(fifo_push) - 2'(fifo_pop);

   surf_word_fifo #(.WIDTH(MEM_DATA_WIDTH)) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (fifo_push),
      .din  (mem_din),
      .pop  (fifo_pop),
      .dout (fifo_dout),
      .occ  (fifo_occ)
   );

   // ---------------- fetch side ----------------
   // The read issued this cycle (mem_en) lands next cycle, so it counts
   // against the two FIFO slots together with next cycle's occupancy.
   assign issue = (state == ST_RUN) && (issue_left != '0) &&
                  ((3'(occ_nx) + 3'(mem_en)) < 3'd2);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_en     <= 1'b0;
         mem_addr   <= '0;
         issue_left <= '0;
         rd_vld     <= 1'b0;
      end else begin
         rd_vld <= mem_en;
         if (accept && (num_words != '0)) begin
            mem_en     <= 1'b1;
            mem_addr   <= base_addr;
            issue_left <= num_words - ADDR_WIDTH'(1);
         end else if (issue) begin
            mem_en     <= 1'b1;
            mem_addr   <= mem_addr + ADDR_WIDTH'(1);
            issue_left <= issue_left - ADDR_WIDTH'(1);
         end else begin
            mem_en <= 1'b0;
         end
      end
   end

   // ---------------- gearbox ----------------
   // PH_1 with nothing left to pop only happens for odd counts: it is the
   // half-filled flush beat carrying the last word's upper 16 bits.
   always_comb begin
      beat_ok    = 1'b0;
      take       = 1'b0;
      beat_data  = '0;
      beat_keep  = KEEP_FULL;
      beat_last  = 1'b0;
      phase_nx   = phase;
      residue_nx = residue;
      case (phase)
         PH_0: begin
            if ((pop_left != '0) && word_avail) begin
               beat_ok    = 1'b1;
               take       = 1'b1;
               beat_data  = word[31:0];
               residue_nx = {16'h0, word[47:32]};
               phase_nx   = PH_1;
            end
         end
         PH_1: begin
            if (pop_left == '0) begin
               beat_ok   = 1'b1;
               beat_data = {16'h0, residue[15:0]};
               beat_keep = KEEP_HALF;
               beat_last = 1'b1;
               phase_nx  = PH_0;
            end else if (word_avail) begin
               beat_ok    = 1'b1;
               take       = 1'b1;
               beat_data  = {word[15:0], residue[15:0]};
               residue_nx = word[47:16];
               phase_nx   = PH_2;
            end
         end
         PH_2: begin
            beat_ok   = 1'b1;
            beat_data = residue;
            beat_last = (pop_left == '0);
            phase_nx  = PH_0;
         end
         default: phase_nx = PH_0;
      endcase
   end

   assign load = (state == ST_RUN) && (!m_axis_tvalid || m_axis_tready) && beat_ok;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase    <= PH_0;
         residue  <= '0;
         pop_left <= '0;
      end else if (accept) begin
         phase    <= PH_0;
         residue  <= '0;
         pop_left <= num_words;
      end else if (load) begin
         phase   <= phase_nx;
         residue <= residue_nx;
         if (take) pop_left <= pop_left - ADDR_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tkeep  <= '0;
         m_axis_tlast  <= 1'b0;
      end else if (load) begin
         m_axis_tvalid <= 1'b1;
         m_axis_tdata  <= beat_data;
         m_axis_tkeep  <= beat_keep;
         m_axis_tlast  <= beat_last;
      end else if (hs) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tkeep  <= '0;
         m_axis_tlast  <= 1'b0;
      end
   end

`ifdef SURF_STREAMER_STALL_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (accept) begin
         stall_cnt <= '0;
      end else if (busy && m_axis_tvalid && !m_axis_tready &&
                   (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_surf_result_streamer.sv
// Self-checking bench for surf_result_streamer. Expected beats come from a
// bit-stream model: words are concatenated little-endian and cut into 32-bit
// beats, a trailing 16-bit remainder becoming a tkeep=3 beat.
module tb_surf_result_streamer;

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [16:0] base_addr;
   logic [16:0] num_words;
   logic        busy;
   logic        done;
   logic [16:0] mem_addr;
   logic        mem_en;
   logic [47:0] mem_din = '0;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b1;
   logic        m_axis_tlast;
   logic [3:0]  m_axis_tkeep;
`ifdef SURF_STREAMER_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   surf_result_streamer dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .base_addr     (base_addr),
      .num_words     (num_words),
      .busy          (busy),
      .done          (done),
      .mem_addr      (mem_addr),
      .mem_en        (mem_en),
      .mem_din       (mem_din),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tkeep  (m_axis_tkeep)
`ifdef SURF_STREAMER_STALL_CNT_EN
      ,
      .stall_cnt     (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   logic [47:0] mem_arr [0:131071];
   always @(posedge clk) if (mem_en) mem_din <= mem_arr[mem_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int rdy_mode = 0;
   always @(posedge clk) begin
      #1;
      m_axis_tready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- monitor ----------------
   beat_t       obs_q[$];
   beat_t       exp_q[$];
   logic [16:0] addr_q[$];
   int          nvalid, first_en, first_vld, ndone, done_cyc, last_hs, stalls;
   logic        done_busy;
   logic        hold_pend = 1'b0;
   logic [37:0] hold_val;

   always @(negedge clk) begin
      if (rst) begin
         if (hold_pend)
            chk("hold", {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast}, hold_val);
         hold_pend = m_axis_tvalid && !m_axis_tready;
         hold_val  = {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast};
         if (m_axis_tvalid && m_axis_tready) begin
            obs_q.push_back({m_axis_tdata, m_axis_tkeep, m_axis_tlast});
            last_hs = cyc;
         end
         if (m_axis_tvalid) begin
            nvalid++;
            if (first_vld < 0) first_vld = cyc;
         end
         if (mem_en) begin
            addr_q.push_back(mem_addr);
            if (first_en < 0) first_en = cyc;
         end
         if (done) begin
            ndone++;
            done_cyc  = cyc;
            done_busy = busy;
         end
         if (busy && m_axis_tvalid && !m_axis_tready) stalls++;
      end else begin
         hold_pend = 1'b0;
      end
   end

   // ---------------- reference model ----------------
   task automatic build_exp(input logic [16:0] base, input int n);
      logic [79:0] acc;
      int          nb;
      beat_t       b;
      exp_q.delete();
      acc = '0;
      nb  = 0;
      for (int k = 0; k < n; k++) begin
         acc = acc | ({32'h0, mem_arr[17'(base + k)]} << nb);
         nb += 48;
         while (nb >= 32) begin
            exp_q.push_back({acc[31:0], 4'hF, 1'b0});
            acc = acc >> 32;
            nb -= 32;
         end
      end
      if (nb > 0) exp_q.push_back({acc[31:0], 4'h3, 1'b0});
      if (exp_q.size() > 0) begin
         b   = exp_q.pop_back();
         b.l = 1'b1;
         exp_q.push_back(b);
      end
   endtask

   task automatic mon_clear();
      obs_q.delete();
      addr_q.delete();
      nvalid    = 0;
      first_en  = -1;
      first_vld = -1;
      ndone     = 0;
      done_cyc  = -1;
      done_busy = 1'b1;
      last_hs   = -1;
      stalls    = 0;
   endtask

   task automatic run_xfer(input logic [16:0] base, input int n, input int mode,
                           input int dup_at, input bit fill, input string nm);
      int s_cyc;
      int budget;
      int m;
      if (fill)
         for (int k = 0; k < n; k++) mem_arr[17'(base + k)] = 48'({$urandom(), $urandom()});
      build_exp(base, n);
      rdy_mode = mode;
      mon_clear();
      @(posedge clk); #1;
      start     = 1'b1;
      base_addr = base;
      num_words = 17'(n);
      s_cyc     = cyc;
      @(posedge clk); #1;
      start  = 1'b0;
      budget = 0;
      while (ndone == 0 && budget < 40 * n + 40) begin
         if (dup_at > 0 && budget == dup_at) begin
            start     = 1'b1;
            base_addr = base + 17'd100;
            num_words = 17'd3;
         end
         @(posedge clk); #1;
         start = 1'b0;
         budget++;
      end
      chk({nm, "_done_seen"}, 64'(ndone > 0), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      chk({nm, "_done_once"}, 64'(ndone), 64'd1);
      chk({nm, "_done_busy"}, 64'(done_busy), 64'd0);
      chk({nm, "_nbeats"}, 64'(obs_q.size()), 64'(exp_q.size()));
      m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < m; i++) chk({nm, "_beat"}, 64'(obs_q[i]), 64'(exp_q[i]));
      chk({nm, "_naddr"}, 64'(addr_q.size()), 64'(n));
      for (int i = 0; i < addr_q.size() && i < n; i++)
         chk({nm, "_addr"}, 64'(addr_q[i]), 64'(17'(base + i)));
      if (n == 0) begin
         chk({nm, "_done_cyc"}, 64'(done_cyc), 64'(s_cyc + 1));
         chk({nm, "_nvalid"}, 64'(nvalid), 64'd0);
      end else begin
         chk({nm, "_first_en"}, 64'(first_en), 64'(s_cyc + 1));
         chk({nm, "_first_vld"}, 64'(first_vld), 64'(s_cyc + 3));
         chk({nm, "_done_cyc"}, 64'(done_cyc), 64'(last_hs + 1));
         if (mode == 0)
            chk({nm, "_nobubble"}, 64'(last_hs - first_vld + 1), 64'(exp_q.size()));
      end
`ifdef SURF_STREAMER_STALL_CNT_EN
      chk({nm, "_stall_cnt"}, 64'(stall_cnt), 64'(stalls));
`endif
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit found;
      rst       = 1'b0;
      start     = 1'b0;
      base_addr = '0;
      num_words = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outs", {busy, done, mem_en, mem_addr, m_axis_tvalid, m_axis_tlast,
                         m_axis_tkeep, m_axis_tdata}, 64'h0);
`ifdef SURF_STREAMER_STALL_CNT_EN
      chk("reset_stall", 64'(stall_cnt), 64'h0);
`endif
      rst = 1'b1;
      repeat (2) @(posedge clk);

      mem_arr[17'h00010] = 48'hAAAA_BBBB_CCCC;
      mem_arr[17'h00011] = 48'h1111_2222_3333;
      run_xfer(17'h00010, 2, 0, 0, 1'b0, "n2");
      if (obs_q.size() == 3) begin
         chk("n2_b0", 64'(obs_q[0]), 64'({32'hBBBB_CCCC, 4'hF, 1'b0}));
         chk("n2_b1", 64'(obs_q[1]), 64'({32'h3333_AAAA, 4'hF, 1'b0}));
         chk("n2_b2", 64'(obs_q[2]), 64'({32'h1111_2222, 4'hF, 1'b1}));
      end

      mem_arr[17'h00400] = 48'h1234_5678_9ABC;
      run_xfer(17'h00400, 1, 0, 0, 1'b0, "n1");
      if (obs_q.size() == 2) begin
         chk("n1_b0", 64'(obs_q[0]), 64'({32'h5678_9ABC, 4'hF, 1'b0}));
         chk("n1_b1", 64'(obs_q[1]), 64'({32'h0000_1234, 4'h3, 1'b1}));
      end

      run_xfer(17'h1FFFE, 4, 0, 0, 1'b1, "wrap");
      run_xfer(17'(($urandom)), 8, 1, 0, 1'b1, "stall8");
      run_xfer(17'h00020, 0, 0, 0, 1'b1, "n0");
      run_xfer(17'h00200, 6, 1, 3, 1'b1, "dup");

      // reset while the second beat of an N=6 transfer is on the bus
      for (int k = 0; k < 6; k++) mem_arr[17'(17'h300 + k)] = 48'({$urandom(), $urandom()});
      rdy_mode = 0;
      mon_clear();
      @(posedge clk); #1;
      start     = 1'b1;
      base_addr = 17'h00300;
      num_words = 17'd6;
      @(posedge clk); #1;
      start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (obs_q.size() == 1 && m_axis_tvalid) found = 1'b1;
         else begin
            @(posedge clk); #1;
         end
      end
      chk("rst_reach_beat2", 64'(found), 64'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("rst_outs", {busy, done, mem_en, mem_addr, m_axis_tvalid, m_axis_tlast,
                       m_axis_tkeep, m_axis_tdata}, 64'h0);
`ifdef SURF_STREAMER_STALL_CNT_EN
      chk("rst_stall", 64'(stall_cnt), 64'h0);
`endif
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk);
      run_xfer(17'h00500, 2, 0, 0, 1'b1, "post_rst");

      for (int t = 0; t < 6; t++)
         run_xfer(17'($urandom), int'($urandom_range(1, 9)), int'($urandom_range(0, 1)),
                  0, 1'b1, "rand");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
